// File: rtl/instruction_data_pkg.sv
// instr_fields_pkg: instruction constant-field positions and default datapath width.
`default_nettype none
package instr_fields_pkg;
   localparam int DATA_W_DEFAULT = 64;
   localparam int IMM12_LSB      = 10;
   localparam int IMM12_W        = 12;
   localparam int SHAMT_LSB      = 10;
   localparam int SHAMT_W        = 6;
   localparam int DADDR_LSB      = 12;
   localparam int DADDR_W        = 9;
endpackage
`default_nettype wire

// File: rtl/instruction_data_if.sv
// instruction_data_if: decode-side request and registered extended-constant response.
`default_nettype none
interface instruction_data_if
   import instr_fields_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
) ();
   logic              in_valid;
   logic [31:0]       instruction;
   logic              I;
   logic              R;
   logic              out_valid;
   logic [DATA_W-1:0] result;

   modport master (
      output in_valid, instruction, I, R,
      input  out_valid, result
   );

   modport slave (
      input  in_valid, instruction, I, R,
      output out_valid, result
   );
endinterface
`default_nettype wire

// File: rtl/instruction_data_fields.sv
// Field helpers: zero/sign extenders and a 2:1 word mux (select=1 picks the low word).
`default_nettype none
module zeroextend #(
   parameter int WIDTH = 12,
   parameter int OUT_W = 64
) (
   input  wire logic [WIDTH-1:0] in,
   output logic      [OUT_W-1:0] out
);
   assign out = {{(OUT_W-WIDTH){1'b0}}, in};
endmodule

module signextend #(
   parameter int WIDTH = 9,
   parameter int OUT_W = 64
) (
   input  wire logic [WIDTH-1:0] in,
   output logic      [OUT_W-1:0] out
);
   assign out = {{(OUT_W-WIDTH){in[WIDTH-1]}}, in};
endmodule

module mux2to1 #(
   parameter int W = 64
) (
   input  wire logic [2*W-1:0] in,
   input  wire logic           select,
   output logic      [W-1:0]   out
);
   // A known select=1 yields the low word even if the other operand is X.
   assign out = select ? in[W-1:0] : in[2*W-1:W];
endmodule
`default_nettype wire

// File: rtl/instruction_data.sv
// instruction_data: selects imm12 / shamt / daddr9 from an instruction, extends
// it to DATA_W bits and registers it with one cycle of latency.
`default_nettype none
module instruction_data
   import instr_fields_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  wire logic          clk,
   input  wire logic          reset_n,
   instruction_data_if.slave  bus
);
   logic [DATA_W-1:0] imm12_ext;
   logic [DATA_W-1:0] shamt_ext;
   logic [DATA_W-1:0] daddr_ext;
   logic [DATA_W-1:0] mux_a;
   logic [DATA_W-1:0] result_d;
   logic [DATA_W-1:0] result_q;
   logic              out_valid_q;
   logic              unused_bits;

   assign unused_bits = ^{bus.instruction[31:22], bus.instruction[9:0]};

   zeroextend #(.WIDTH(IMM12_W), .OUT_W(DATA_W)) u_imm12 (
      .in  (bus.instruction[IMM12_LSB +: IMM12_W]),
      .out (imm12_ext)
   );

   zeroextend #(.WIDTH(SHAMT_W), .OUT_W(DATA_W)) u_shamt (
      .in  (bus.instruction[SHAMT_LSB +: SHAMT_W]),
      .out (shamt_ext)
   );

   signextend #(.WIDTH(DADDR_W), .OUT_W(DATA_W)) u_daddr (
      .in  (bus.instruction[DADDR_LSB +: DADDR_W]),
      .out (daddr_ext)
   );

   mux2to1 #(.W(DATA_W)) u_mux_a (
      .in     ({daddr_ext, shamt_ext}),
      .select (bus.R),
      .out    (mux_a)
   );

   // I has priority: R only matters for the non-immediate forms.
   mux2to1 #(.W(DATA_W)) u_mux_b (
      .in     ({mux_a, imm12_ext}),
      .select (bus.I),
      .out    (result_d)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            result_q <= result_d;
         end
      end
   end

   assign bus.result    = result_q;
   assign bus.out_valid = out_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_instruction_data.sv
// Directed bench for instruction_data: field selection, bubble, reset and streaming.
`default_nettype none
module tb_instruction_data;
   localparam logic [31:0] INSTR_A = 32'hD3512800;
   localparam logic [31:0] INSTR_B = 32'hD34FF800;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_errors;

   instruction_data_if #(.DATA_W(64)) bus ();

   instruction_data #(.DATA_W(64)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic i, input logic r);
      @(negedge clk);
      bus.in_valid    = v;
      bus.instruction = instr;
      bus.I           = i;
      bus.R           = r;
   endtask

   task automatic capture_check(input string tag, input logic [63:0] exp);
      @(posedge clk);
      #1;
      check1({tag, "_vld"}, bus.out_valid, 1'b1);
      check64(tag, bus.result, exp);
   endtask

   typedef struct {
      logic        i;
      logic        r;
      logic [31:0] instr;
      logic [63:0] exp;
   } vec_t;

   vec_t stream [6];

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset_n         = 1'b0;
      bus.in_valid    = 1'b1;
      bus.instruction = INSTR_A;
      bus.I           = 1'b1;
      bus.R           = 1'b0;

      // Reset held across an edge with valid input present.
      @(posedge clk);
      #1;
      check64("reset_result", bus.result, 64'h0);
      check1("reset_vld", bus.out_valid, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;

      drive(1'b1, INSTR_A, 1'b1, 1'b0);
      capture_check("i1_r0", 64'h0000_0000_0000_044A);
      drive(1'b1, INSTR_A, 1'b1, 1'b1);
      capture_check("i1_r1", 64'h0000_0000_0000_044A);
      drive(1'b1, INSTR_A, 1'b1, 1'bx);
      capture_check("i1_rx", 64'h0000_0000_0000_044A);
      drive(1'b1, INSTR_A, 1'b0, 1'b1);
      capture_check("shamt", 64'h0000_0000_0000_000A);
      drive(1'b1, INSTR_A, 1'b0, 1'b0);
      capture_check("daddr_neg", 64'hFFFF_FFFF_FFFF_FF12);
      drive(1'b1, INSTR_B, 1'b0, 1'b0);
      capture_check("daddr_pos", 64'h0000_0000_0000_00FF);

      // Bubble: valid drops, result holds, even with different inputs present.
      drive(1'b0, INSTR_A, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      check1("bubble_vld", bus.out_valid, 1'b0);
      check64("bubble_hold", bus.result, 64'h0000_0000_0000_00FF);

      // Mid-cycle asynchronous reset.
      drive(1'b1, INSTR_A, 1'b0, 1'b0);
      capture_check("pre_reset", 64'hFFFF_FFFF_FFFF_FF12);
      #2;
      reset_n = 1'b0;
      #1;
      check64("async_rst_result", bus.result, 64'h0);
      check1("async_rst_vld", bus.out_valid, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      bus.in_valid    = 1'b1;
      bus.instruction = INSTR_A;
      bus.I           = 1'b0;
      bus.R           = 1'b1;
      capture_check("post_reset", 64'h0000_0000_0000_000A);

      // Back-to-back stream with changing I/R every cycle.
      stream[0] = '{1'b1, 1'b0, INSTR_A, 64'h0000_0000_0000_044A};
      stream[1] = '{1'b0, 1'b1, INSTR_A, 64'h0000_0000_0000_000A};
      stream[2] = '{1'b0, 1'b0, INSTR_A, 64'hFFFF_FFFF_FFFF_FF12};
      stream[3] = '{1'b0, 1'b0, INSTR_B, 64'h0000_0000_0000_00FF};
      stream[4] = '{1'b0, 1'b1, INSTR_B, 64'h0000_0000_0000_003E};
      stream[5] = '{1'b1, 1'b1, INSTR_B, 64'h0000_0000_0000_03FE};
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, stream[k].instr, stream[k].i, stream[k].r);
         capture_check($sformatf("stream%0d", k), stream[k].exp);
      end

      drive(1'b0, INSTR_A, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check1("tail_vld", bus.out_valid, 1'b0);
      check64("tail_hold", bus.result, 64'h0000_0000_0000_03FE);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
